// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gating issue on RAW hazards.
// Optional writeback-to-issue forwarding is enabled by defining SCOREBOARD_BYPASS_EN.
module reg_scoreboard #(
    parameter int unsigned REG_FILE_SIZE = 20,
    parameter int unsigned CNT_W         = 2,
    parameter int unsigned STALL_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [7:0]               issue_src1,
    input  logic [7:0]               issue_src2,
    input  logic [7:0]               issue_dst,
    input  logic [1:0]               wb_valid,
    input  logic [7:0]               wb_reg0,
    input  logic [7:0]               wb_reg1,
    input  logic                     flush,
    output logic [REG_FILE_SIZE-1:0] busy_vec,
    output logic                     err,
    output logic [STALL_W-1:0]       stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q [REG_FILE_SIZE];
    logic [CNT_W-1:0]     cnt_d [REG_FILE_SIZE];
    logic                 err_q, err_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [REG_FILE_SIZE-1:0] src1_hit, src2_hit, dst_hit, wb_hit0, wb_hit1;
    logic [REG_FILE_SIZE-1:0] busy_now, sat, underflow;
    logic                     accept, run_active, bad_id;

    function automatic logic is_real(input logic [7:0] id);
        return id[7] && (32'(id[6:0]) < REG_FILE_SIZE);
    endfunction

    function automatic logic is_bad(input logic [7:0] id);
        return id[7] && (32'(id[6:0]) >= REG_FILE_SIZE);
    endfunction

    // Fake and invalid ids never match any tracked register.
    always_comb begin
        for (int i = 0; i < int'(REG_FILE_SIZE); i++) begin
            src1_hit[i] = is_real(issue_src1) && (issue_src1[6:0] == 7'(i));
            src2_hit[i] = is_real(issue_src2) && (issue_src2[6:0] == 7'(i));
            dst_hit[i]  = is_real(issue_dst) && (issue_dst[6:0] == 7'(i));
            wb_hit0[i]  = wb_valid[0] && is_real(wb_reg0) && (wb_reg0[6:0] == 7'(i));
            wb_hit1[i]  = wb_valid[1] && is_real(wb_reg1) && (wb_reg1[6:0] == 7'(i));
            busy_now[i] = cnt_q[i] != '0;
`ifdef SCOREBOARD_BYPASS_EN
            if (cnt_q[i] == CNT_W'(1) && (wb_hit0[i] || wb_hit1[i])) begin
                busy_now[i] = 1'b0;
            end
`endif
            sat[i]      = cnt_q[i] == CNT_MAX;
            busy_vec[i] = cnt_q[i] != '0;
        end
    end

    assign run_active  = (state_q == StRun) && !flush;
    assign issue_ready = run_active && !(|(src1_hit & busy_now)) && !(|(src2_hit & busy_now))
                         && !(|(dst_hit & sat));
    assign accept      = issue_valid && issue_ready;

    always_comb begin
        logic [CNT_W:0] sum;
        logic [CNT_W:0] dec;
        for (int i = 0; i < int'(REG_FILE_SIZE); i++) begin
            sum          = (CNT_W+1)'(cnt_q[i]) + (CNT_W+1)'(accept && dst_hit[i]);
            dec          = (CNT_W+1)'(wb_hit0[i]) + (CNT_W+1)'(wb_hit1[i]);
            underflow[i] = 1'b0;
            cnt_d[i]     = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (state_q == StRun) begin
                if (sum < dec) begin
                    cnt_d[i]     = '0;
                    underflow[i] = 1'b1;
                end else begin
                    cnt_d[i] = CNT_W'(sum - dec);
                end
            end
        end
    end

    // Writebacks seen while flushing are dropped silently, so errors only count in RUN.
    assign bad_id = (issue_valid && (is_bad(issue_src1) || is_bad(issue_src2)
                                     || is_bad(issue_dst)))
                    || (wb_valid[0] && is_bad(wb_reg0))
                    || (wb_valid[1] && is_bad(wb_reg1));

    always_comb begin
        err_d   = err_q | (run_active && (bad_id || (|underflow)));
        stall_d = stall_q;
        if (issue_valid && !issue_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (flush)  state_d = StFlush;
            StFlush: if (!flush) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            err_q   <= 1'b0;
            stall_q <= '0;
            for (int i = 0; i < int'(REG_FILE_SIZE); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            for (int i = 0; i < int'(REG_FILE_SIZE); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign err       = err_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares the entries due in the current cycle.
module tb_reg_scoreboard;

    localparam int unsigned N = 20;
`ifdef SCOREBOARD_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam int K_RDY = 0, K_BUSY = 1, K_ERR = 2, K_STALL = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         issue_valid;
    logic         issue_ready;
    logic [7:0]   issue_src1, issue_src2, issue_dst;
    logic [1:0]   wb_valid;
    logic [7:0]   wb_reg0, wb_reg1;
    logic         flush;
    logic [N-1:0] busy_vec;
    logic         err;
    logic [15:0]  stall_cnt;

    reg_scoreboard #(.REG_FILE_SIZE(N), .CNT_W(2), .STALL_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_src1  (issue_src1),
        .issue_src2  (issue_src2),
        .issue_dst   (issue_dst),
        .wb_valid    (wb_valid),
        .wb_reg0     (wb_reg0),
        .wb_reg1     (wb_reg1),
        .flush       (flush),
        .busy_vec    (busy_vec),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                K_RDY:   act = 32'(issue_ready);
                K_BUSY:  act = 32'(busy_vec);
                K_ERR:   act = 32'(err);
                default: act = 32'(stall_cnt);
            endcase
            total++;
            if (e.cyc != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h (cycle %0d, due %0d)",
                         e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic chk(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    // Waits for the next edge, then drives one cycle of inputs.
    task automatic step(input logic v, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] d, input logic [1:0] wv, input logic [7:0] w0,
                        input logic [7:0] w1, input logic fl);
        @(posedge clk);
        #1;
        issue_valid = v;
        issue_src1  = s1;
        issue_src2  = s2;
        issue_dst   = d;
        wb_valid    = wv;
        wb_reg0     = w0;
        wb_reg1     = w1;
        flush       = fl;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic issue(input logic [7:0] s1, input logic [7:0] d);
        step(1'b1, s1, 8'h00, d, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        issue_valid = 1'b0;
        issue_src1  = 8'h00;
        issue_src2  = 8'h00;
        issue_dst   = 8'h00;
        wb_valid    = 2'b00;
        wb_reg0     = 8'h00;
        wb_reg1     = 8'h00;
        flush       = 1'b0;
        repeat (3) @(posedge clk);
        idle();
        reset_n = 1'b1;
        chk("rst_busy", K_BUSY, 0);
        chk("rst_err", K_ERR, 0);
        chk("rst_stall", K_STALL, 0);
        chk("rst_ready", K_RDY, 1);

        // RAW on rax
        issue(8'h00, 8'h80);
        chk("t1_first_ready", K_RDY, 1);
        issue(8'h80, 8'h00);
        chk("t1_busy_rax", K_BUSY, 32'h1);
        chk("t1_raw_ready", K_RDY, 0);
        step(1'b1, 8'h80, 8'h00, 8'h00, 2'b01, 8'h80, 8'h00, 1'b0);
        chk("t1_stall", K_STALL, 1);
        chk("t2_wb_cycle_ready", K_RDY, 32'(BYP));
        issue(8'h80, 8'h00);
        chk("t2_busy_clear", K_BUSY, 0);
        chk("t2_ready_after_wb", K_RDY, 1);
        chk("t2_stall", K_STALL, 32'(2 - BYP));

        // Saturation on rcx
        issue(8'h00, 8'h81);
        chk("t3_rcx_1", K_RDY, 1);
        issue(8'h00, 8'h81);
        chk("t3_rcx_2", K_RDY, 1);
        chk("t3_busy_rcx", K_BUSY, 32'h2);
        issue(8'h00, 8'h81);
        chk("t3_rcx_3", K_RDY, 1);
        issue(8'h00, 8'h81);
        chk("t3_sat_ready", K_RDY, 0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h81, 8'h00, 1'b0);
        chk("t3_stall_sat", K_STALL, 32'(3 - BYP));
        step(1'b1, 8'h00, 8'h00, 8'h81, 2'b11, 8'h81, 8'h81, 1'b0);
        chk("t3_dual_wb_ready", K_RDY, 1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h81, 8'h00, 1'b0);
        chk("t3_cnt_one_busy", K_BUSY, 32'h2);
        idle();
        chk("t3_cnt_drained", K_BUSY, 0);
        chk("t3_no_underflow", K_ERR, 0);

        // Fake and invalid ids
        step(1'b1, 8'h01, 8'h02, 8'h03, 2'b00, 8'h00, 8'h00, 1'b0);
        chk("t4_fake_ready_a", K_RDY, 1);
        step(1'b1, 8'h00, 8'h04, 8'h04, 2'b00, 8'h00, 8'h00, 1'b0);
        chk("t4_fake_ready_b", K_RDY, 1);
        chk("t4_fake_busy", K_BUSY, 0);
        chk("t4_err_clean", K_ERR, 0);
        issue(8'h00, 8'h95);
        chk("t4_invalid_ready", K_RDY, 1);
        idle();
        chk("t4_invalid_err", K_ERR, 1);
        chk("t4_invalid_busy", K_BUSY, 0);
        issue(8'h00, 8'h88);
        chk("t4_err_sticky", K_ERR, 1);

        // Reset mid-operation with r8 pending
        idle();
        reset_n = 1'b0;
        chk("t5_rst_busy", K_BUSY, 0);
        chk("t5_rst_err", K_ERR, 0);
        idle();
        reset_n = 1'b1;
        chk("t5_rel_stall", K_STALL, 0);
        chk("t5_rel_ready", K_RDY, 1);
        issue(8'h00, 8'h80);
        step(1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h82, 8'h00, 1'b0);
        chk("t5_pre_uf_busy", K_BUSY, 32'h1);
        chk("t5_pre_uf_err", K_ERR, 0);
        idle();
        chk("t5_uf_err", K_ERR, 1);
        chk("t5_uf_busy", K_BUSY, 32'h1);
        idle();
        chk("t5_uf_sticky", K_ERR, 1);

        // Flush with pending r8/r9
        issue(8'h00, 8'h88);
        issue(8'h00, 8'h89);
        chk("t6_pre_busy_r8", K_BUSY, 32'h101);
        step(1'b1, 8'h00, 8'h00, 8'h8a, 2'b11, 8'h88, 8'h89, 1'b1);
        chk("t6_flush_ready", K_RDY, 0);
        chk("t6_flush_busy", K_BUSY, 32'h301);
        step(1'b1, 8'h00, 8'h00, 8'h8a, 2'b11, 8'h80, 8'h80, 1'b0);
        chk("t6_cleared", K_BUSY, 0);
        chk("t6_deassert_ready", K_RDY, 0);
        issue(8'h00, 8'h00);
        chk("t6_run_ready", K_RDY, 1);
        chk("t6_stall", K_STALL, 2);
        idle();
        chk("t6_wb_ignored", K_BUSY, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending checks want 0", q.size());
            bad = bad + 1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
